// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Used by the top, the priority sub-module and the bus interface users.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } own_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    function automatic int lat_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and single-memory signals of the unified arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_funct3, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_funct3, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/unified_mem_arbiter_prio.sv
// Grant selection between fetch and data requests; data normally wins.
// FETCH_STARVE_GUARD_EN adds a streak counter that lets fetch through once.
module mem_arb_prio
    import mem_arb_pkg::*;
`ifdef FETCH_STARVE_GUARD_EN
#(
    parameter int MAX_DATA_STREAK = 4
)
`endif
(
`ifdef FETCH_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic idle,
    input  logic if_req,
    input  logic d_req,
    output logic grant,
    output own_t grant_owner
);

    logic fetch_turn;

`ifdef FETCH_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    logic [STREAK_W-1:0] streak_q;

    assign fetch_turn = if_req && (!d_req || streak_q == STREAK_W'(MAX_DATA_STREAK));

    // Only data grants that actually made fetch wait count toward the streak.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else if (grant) begin
            if (grant_owner == OWN_IF) begin
                streak_q <= '0;
            end else if (if_req) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
        end
    end
`else
    assign fetch_turn = if_req && !d_req;
`endif

    assign grant       = idle && (if_req || d_req);
    assign grant_owner = fetch_turn ? OWN_IF : OWN_D;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between fetch and load/store ports.
// Optional fetch starvation guard: define FETCH_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | accept at most one request (data before fetch)
// ISSUE | mem_en strobe, one cycle
// WAIT  | remaining MEM_LATENCY-1 cycles, down-counter to zero
// RESP  | mem_rdata valid, owner's rvalid pulses
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus
);

    localparam int CNT_W = lat_cnt_w(MEM_LATENCY);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || MAX_DATA_STREAK < 1) begin : g_bad_param
        $error("unified_mem_arbiter: MEM_LATENCY must be 1..15 and MAX_DATA_STREAK >= 1");
    end

    state_t            state_q;
    own_t              owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [2:0]        mem_funct3_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic idle;
    logic grant;
    own_t grant_owner;

    assign idle = (state_q == IDLE) && !rst;

    mem_arb_prio
`ifdef FETCH_STARVE_GUARD_EN
        #(.MAX_DATA_STREAK(MAX_DATA_STREAK))
`endif
    u_prio (
`ifdef FETCH_STARVE_GUARD_EN
        .clk         (clk),
        .rst         (rst),
`endif
        .idle        (idle),
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .grant       (grant),
        .grant_owner (grant_owner)
    );

    assign bus.d_ready  = grant && (grant_owner == OWN_D);
    assign bus.if_ready = grant && (grant_owner == OWN_IF);
    assign bus.busy     = (state_q != IDLE) || bus.if_req || bus.d_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_funct3_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            mem_en_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q  <= ISSUE;
                        mem_en_q <= 1'b1;
                        owner_q  <= grant_owner;
                        if (grant_owner == OWN_D) begin
                            mem_we_q     <= bus.d_we;
                            mem_funct3_q <= bus.d_funct3;
                            mem_addr_q   <= bus.d_addr;
                            mem_wdata_q  <= bus.d_wdata;
                        end else begin
                            mem_we_q     <= 1'b0;
                            mem_funct3_q <= FUNCT3_WORD;
                            mem_addr_q   <= bus.if_addr;
                            mem_wdata_q  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (MEM_LATENCY == 1) begin
                        state_q     <= RESP;
                        if_rvalid_q <= (owner_q == OWN_IF);
                        d_rvalid_q  <= (owner_q == OWN_D);
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_W'(MEM_LATENCY - 2);
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        if_rvalid_q <= (owner_q == OWN_IF);
                        d_rvalid_q  <= (owner_q == OWN_D);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rdata_q <= bus.mem_rdata;
                    end else begin
                        d_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory data arrives during RESP, so the pulse cycle passes it straight through.
    assign bus.if_rdata   = if_rvalid_q ? bus.mem_rdata : if_rdata_q;
    assign bus.d_rdata    = d_rvalid_q ? (mem_we_q ? '0 : bus.mem_rdata) : d_rdata_q;
    assign bus.if_rvalid  = if_rvalid_q;
    assign bus.d_rvalid   = d_rvalid_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_funct3 = mem_funct3_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
